// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a one-entry
// valid/ready holding register with single-cycle framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] dbg_state_o
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          rx_meta_q;
  logic          rx_s_q;
  logic [7:0]    rx_data_q;
  logic          rx_valid_q;
  logic          frame_err_q;
  logic          overrun_q;

  // Holding register handshake: a byte moves to the host on any cycle where
  // rx_valid and rx_ready are both high; rx_data is frozen until then, and a
  // delivery in the same cycle as an acceptance refills the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) state_q <= S_START;
        end
        S_START: begin
          // Half a bit in: a line that is high again was only a glitch.
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               idx_q   <= idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              if (!rx_valid_q || rx_ready) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_BREAK: begin
          // A held-low line must go high before another start bit counts.
          if (rx_s_q) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: reset check, directed corner sequences, a vector table of
// single frames and randomized traffic against a byte-queue reference model.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       host_ready = 1'b0;
  logic       rnd_ready = 1'b0;
  logic       rnd_on = 1'b0;
  logic       ready_w;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [2:0] dbg_state;

  assign ready_w = rnd_on ? rnd_ready : host_ready;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(ready_w),
    .frame_err(frame_err), .overrun(overrun), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int ferr_cnt = 0, ovr_cnt = 0, rise_cnt = 0, rise_cyc = 0;
  int long_pulse = 0, unstable = 0, state_mis = 0;
  logic valid_prev = 0, ferr_prev = 0, ovr_prev = 0, hs_prev = 0;
  logic [7:0] data_prev = '0;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if ((frame_err && ferr_prev) || (overrun && ovr_prev)) long_pulse++;
      if (rx_valid && !valid_prev) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      if (rx_valid && valid_prev && !hs_prev && rx_data !== data_prev) unstable++;
      if (busy !== (dbg_state != 3'd0)) state_mis++;
      if (rx_valid && ready_w) begin
        got_q.push_back(rx_data);
        if (rnd_on) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL rnd_extra_byte: got 0x%0h expected no byte", rx_data);
          end else begin
            check("rnd_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
          end
        end
      end
    end
    valid_prev = rx_valid;
    ferr_prev  = frame_err;
    ovr_prev   = overrun;
    hs_prev    = rx_valid && ready_w;
    data_prev  = rx_data;
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  int start_cyc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic accept();
    host_ready = 1'b1;
    tick();
    host_ready = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  int   r0, f0, o0, bad, lat, exp_ferr, gap;
  logic seen, seen2;
  logic [7:0] d7, rb;
  logic bad_stop;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
    vecs[2] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 8'h00, 1};
    vecs[5] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 0};

    // Reset values
    repeat (4) tick();
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    reset = 1'b0;
    repeat (4) tick();

    // 0xA5: latency window, 50-cycle hold, acceptance
    send_frame(8'hA5, 1'b1);
    lat = rise_cyc - start_cyc;
    check("a5_latency_in_window", (lat >= 152 && lat <= 156), 1);
    check("a5_one_delivery", rise_cnt, 1);
    bad = 0;
    repeat (50) begin
      tick();
      if (!(rx_valid === 1'b1 && rx_data === 8'hA5)) bad++;
    end
    check("a5_hold_50", bad, 0);
    accept();
    check("a5_valid_after_accept", rx_valid, 0);
    check("a5_no_frame_err", ferr_cnt, 0);
    check("a5_no_overrun", ovr_cnt, 0);

    // Start-bit glitch
    r0 = rise_cnt; f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= busy;
    end
    check("glitch_busy_seen", seen, 1);
    check("glitch_back_idle", busy, 0);
    check("glitch_no_valid", rise_cnt, r0);
    check("glitch_no_ferr", ferr_cnt, f0);
    send_frame(8'h3C, 1'b1);
    check("glitch_next_valid", rx_valid, 1);
    check("glitch_next_data", rx_data, 8'h3C);
    accept();

    // Framing error with line held low
    r0 = rise_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (!busy) seen = 1'b1;
    end
    check("ferr_one_pulse", ferr_cnt - f0, 1);
    check("ferr_no_valid", rise_cnt, r0);
    check("ferr_busy_held", seen, 0);
    rx = 1'b1;
    repeat (5) tick();
    check("ferr_idle_after_high", busy, 0);
    send_frame(8'h81, 1'b1);
    check("ferr_next_valid", rx_valid, 1);
    check("ferr_next_data", rx_data, 8'h81);
    accept();

    // Overrun: back-to-back with host stalled
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick();
    check("ovr_one_pulse", ovr_cnt - o0, 1);
    check("ovr_valid_kept", rx_valid, 1);
    check("ovr_data_kept", rx_data, 8'h11);
    accept();
    check("ovr_drained", rx_valid, 0);

    // Back-to-back with host always ready
    got_q.delete();
    o0 = ovr_cnt;
    host_ready = 1'b1;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (4) tick();
    host_ready = 1'b0;
    check("b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b_first", got_q[0], 8'h00);
      check("b2b_second", got_q[1], 8'hFF);
    end
    check("b2b_no_overrun", ovr_cnt, o0);

    // Reset during data bit 4 of 0x77
    r0 = rise_cnt;
    d7 = 8'h77;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d7[i]);
    rx = d7[4];
    repeat (8) tick();
    reset = 1'b1;
    tick();
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun", overrun, 0);
    reset = 1'b0;
    rx = 1'b1;
    repeat (20) tick();
    check("midrst_no_delivery", rise_cnt, r0);
    send_frame(8'h5A, 1'b1);
    check("midrst_next_data", rx_data, 8'h5A);
    accept();

    // Vector table: single frames from idle, empty holding register
    for (int v = 0; v < 6; v++) begin
      f0 = ferr_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      rx = 1'b1;
      repeat (4) tick();
      check("vec_valid", rx_valid, vecs[v].exp_valid);
      if (vecs[v].exp_valid) check("vec_data", rx_data, vecs[v].exp_data);
      check("vec_ferr", ferr_cnt - f0, vecs[v].exp_ferr);
      if (rx_valid) accept();
    end

    // Randomized traffic with a randomly stalling host
    f0 = ferr_cnt; o0 = ovr_cnt; exp_ferr = 0;
    exp_q.delete();
    rnd_on = 1'b1;
    for (int n = 0; n < 30; n++) begin
      rb = 8'($urandom_range(0, 255));
      bad_stop = ($urandom_range(0, 5) == 0);
      if (bad_stop) exp_ferr++;
      else exp_q.push_back(rb);
      send_frame(rb, !bad_stop);
      rx = 1'b1;
      gap = bad_stop ? $urandom_range(4, 20) : $urandom_range(0, 20);
      repeat (gap) tick();
    end
    repeat (300) tick();
    rnd_on = 1'b0;
    tick();
    check("rnd_all_delivered", exp_q.size(), 0);
    check("rnd_frame_errs", ferr_cnt - f0, exp_ferr);
    check("rnd_no_overrun", ovr_cnt - o0, 0);

    // Whole-run invariants
    check("flag_pulse_width", long_pulse, 0);
    check("data_stable_while_valid", unstable, 0);
    check("busy_matches_state", state_mis, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
